muldiv_iterative_unit: RTL and testbench

- Parametrised successor to the separate multiplier and divider blocks in the multicycle datapath.
- Single shared iterative engine executing all eight RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Configurable word width and bits retired per cycle.
- Sits beside the ALU. Fed from SrcA/SrcB. Result goes into the MULExtResult path of the Result mux. Handshakes with the control unit via valid/ready.

---
 rtl/muldiv_iterative_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_iterative_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iterative_unit.sv
// Shared iterative multiply/divide engine for the eight RV M-extension ops.
// Optional macro MULDIV_EARLY_OUT_EN: trivial cases bypass CALC (IDLE -> FIXUP -> DONE).
module muldiv_iterative_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            busy,
  output logic            div_by_zero
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state, state_nxt;
  logic            valid_q;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_a_q, neg_b_q;
  logic            dz_q, ovf_q, mzero_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN-1:0] hi_q, lo_q;

  logic            accept, early_in;
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic            in_dz, in_ovf, in_mzero;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] hi_s, lo_s;
  logic [XLEN:0]   sum, trial;
  logic [XLEN-1:0] quo, rem, fix_result;
  logic [2*XLEN-1:0] prod;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign accept = (state == IDLE) && valid && !valid_q;

  // Signedness: MULH/MULHSU/DIV/REM treat a as signed; only MULH/DIV/REM treat b as signed.
  assign sgn_a  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign sgn_b  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign neg_a  = sgn_a && a[XLEN-1];
  assign neg_b  = sgn_b && b[XLEN-1];
  assign mag_a  = cond_neg(a, neg_a);
  assign mag_b  = cond_neg(b, neg_b);

  assign in_dz    = op[2] && (b == '0);
  assign in_ovf   = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign in_mzero = !op[2] && ((a == '0) || (b == '0));

`ifdef MULDIV_EARLY_OUT_EN
  assign early_in = in_dz || in_ovf || in_mzero;
`else
  assign early_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = early_in ? FIXUP : CALC;
      CALC:    if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

  // Iteration: multiply keeps {hi, lo} as the shifting product; divide keeps remainder in hi, quotient in lo.
  always_comb begin
    hi_s  = hi_q;
    lo_s  = lo_q;
    sum   = '0;
    trial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!op_q[2]) begin
        sum  = {1'b0, hi_s} + (lo_s[0] ? {1'b0, d_q} : '0);
        lo_s = {sum[0], lo_s[XLEN-1:1]};
        hi_s = sum[XLEN:1];
      end else begin
        trial = {hi_s, lo_s[XLEN-1]};
        lo_s  = {lo_s[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, d_q}) begin
          hi_s    = trial[XLEN-1:0] - d_q;
          lo_s[0] = 1'b1;
        end else begin
          hi_s = trial[XLEN-1:0];
        end
      end
    end
  end

  assign prod = cond_neg_wide({hi_q, lo_q}, neg_a_q ^ neg_b_q);
  assign quo  = cond_neg(lo_q, neg_a_q ^ neg_b_q);
  assign rem  = cond_neg(hi_q, neg_a_q);

  always_comb begin
    fix_result = '0;
    case (op_q)
      3'b000:         fix_result = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_result = dz_q ? '1 : (ovf_q ? a_q : quo);
      default:        fix_result = dz_q ? a_q : (ovf_q ? '0 : rem);
    endcase
    if (mzero_q) fix_result = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid_q <= valid;
      if (accept) begin
        cnt         <= CW'(N - 1);
        div_by_zero <= 1'b0;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
      end
      if (state == FIXUP) begin
        result      <= fix_result;
        div_by_zero <= dz_q;
      end
    end
  end

  // Operand capture at acceptance, then iterate while in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      a_q     <= a;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      dz_q    <= in_dz;
      ovf_q   <= in_ovf;
      mzero_q <= in_mzero;
      hi_q    <= '0;
      lo_q    <= op[2] ? mag_a : mag_b;
      d_q     <= op[2] ? mag_b : mag_a;
    end else if (state == CALC) begin
      hi_q <= hi_s;
      lo_q <= lo_s;
    end
  end

endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Directed bench for muldiv_iterative_unit: BPC=1 instance plus a BPC=4 instance for a model-checked sweep.
module tb_muldiv_iterative_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid1 = 1'b0, valid4 = 1'b0;
  logic [2:0]  op1 = '0, op4 = '0;
  logic [31:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
  logic [31:0] res1, res4;
  logic        rdy1, rdy4, busy1, busy4, dz1, dz4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_iterative_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .resetn(resetn), .valid(valid1), .op(op1), .a(a1), .b(b1),
    .result(res1), .ready(rdy1), .busy(busy1), .div_by_zero(dz1)
  );

  muldiv_iterative_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .resetn(resetn), .valid(valid4), .op(op4), .a(a4), .b(b4),
    .result(res4), .ready(rdy4), .busy(busy4), .div_by_zero(dz4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return (o[2] && y == 0) || (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
        || (!o[2] && (x == 0 || y == 0));
  endfunction

  function automatic int exp_lat(input int n, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (is_special(o, x, y)) return 2;
`endif
    return n + 2;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy, p;
    logic        [63:0] up;
    logic signed [31:0] x32, y32, t;
    sx = $signed(x);
    sy = $signed(y);
    uy = {32'b0, y};
    x32 = x;
    y32 = y;
    case (o)
      3'b000: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        t = x32 / y32; return t;
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        t = x32 % y32; return t;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Launch one op; latency = number of edges from acceptance (edge 1) to the edge after which ready is high.
  task automatic do_op(input bit sel, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold, output logic [31:0] r, output logic dz, output int lat,
                       output int busy_bad);
    bit done;
    @(negedge clk);
    if (sel) begin op4 = o; a4 = x; b4 = y; valid4 = 1'b1; end
    else     begin op1 = o; a1 = x; b1 = y; valid1 = 1'b1; end
    lat = 0; busy_bad = 0; done = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && !hold) begin
        if (sel) begin a4 = ~x; b4 = x ^ y; op4 = ~o; valid4 = 1'b0; end
        else     begin a1 = ~x; b1 = x ^ y; op1 = ~o; valid1 = 1'b0; end
      end
      if (!(sel ? busy4 : busy1)) busy_bad++;
      if (sel ? rdy4 : rdy1) done = 1;
    end
    if (!done) lat = -1;
    r  = sel ? res4 : res1;
    dz = sel ? dz4 : dz1;
    if (!hold) begin
      @(posedge clk); #1;
      if (sel ? busy4 : busy1) busy_bad++;
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  initial begin
    vec_t        vecs[12];
    logic [31:0] r;
    logic        dz;
    int          lat, bb;
    logic [2:0]  o;
    logic [31:0] x, y;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[7]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{3'b111, 32'd5,          32'd0,         32'd5,         1'b1};
    vecs[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[11] = '{3'b000, 32'h0,          32'h1234_5678, 32'h0,         1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", res1, 0);
    chk("reset_ready", rdy1, 0);
    chk("reset_busy", busy1, 0);
    chk("reset_dz", dz1, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(1'b0, vecs[i].o, vecs[i].x, vecs[i].y, 1'b0, r, dz, lat, bb);
      chk($sformatf("v%0d_result", i), r, vecs[i].r);
      chk($sformatf("v%0d_dz", i), dz, vecs[i].dz);
      chk($sformatf("v%0d_latency", i), lat, exp_lat(32, vecs[i].o, vecs[i].x, vecs[i].y));
      chk($sformatf("v%0d_busy", i), bb, 0);
    end

    // Valid held high after ready must not relaunch.
    do_op(1'b0, 3'b011, 32'd3, 32'd9, 1'b1, r, dz, lat, bb);
    chk("hold_result", r, 32'd0);
    chk("hold_latency", lat, 34);
    bb = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy1 || rdy1) bb++;
    end
    chk("hold_no_relaunch", bb, 0);
    @(negedge clk);
    valid1 = 1'b0;
    @(posedge clk);

    // Leave nonzero result and div_by_zero set, then reset mid-CALC.
    do_op(1'b0, 3'b101, 32'd77, 32'd0, 1'b0, r, dz, lat, bb);
    chk("pre_reset_dz", dz, 1);
    @(negedge clk);
    op1 = 3'b000; a1 = 32'd11; b1 = 32'd13; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("calc_busy_before_reset", busy1, 1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midop_reset_ready", rdy1, 0);
    chk("midop_reset_result", res1, 0);
    chk("midop_reset_busy", busy1, 0);
    chk("midop_reset_dz", dz1, 0);
    @(negedge clk);
    resetn = 1'b1;
    bb = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy1) bb++;
    end
    chk("no_ready_after_abort", bb, 0);
    do_op(1'b0, 3'b000, 32'd11, 32'd13, 1'b0, r, dz, lat, bb);
    chk("post_reset_result", r, 32'd143);
    chk("post_reset_latency", lat, 34);

    // BPC=4 sweep against the reference model.
    for (int i = 0; i < 1000; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 15))
        0: y = 32'h0;
        1: x = 32'h0;
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = 32'($urandom_range(1, 15));
        4: y = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(1'b1, o, x, y, 1'b0, r, dz, lat, bb);
      chk($sformatf("sweep%0d_op%0d_%h_%h", i, o, x, y), r, ref_res(o, x, y));
      chk($sformatf("sweep%0d_latency", i), lat, exp_lat(8, o, x, y));
      chk($sformatf("sweep%0d_dz", i), dz, o[2] && (y == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
